// File: rtl/pbch_dmrs_ibar_detector.sv
// pbch_dmrs_ibar_detector: PBCH DMRS Gold-sequence generator and soft-metric ibar_SSB detector
module pbch_dmrs_ibar_detector #(
   parameter int IN_DW = 32,
   parameter int NFFT  = 8,
   parameter int N_HYP = 8,
   parameter int N_SYM = 3
) (
   input  logic                clk_i,
   input  logic                reset_ni,
   input  logic [IN_DW-1:0]    s_axis_in_tdata,
   input  logic                s_axis_in_tvalid,
   input  logic [9:0]          N_id_i,
   input  logic                N_id_valid_i,
   input  logic                PBCH_start_i,
   output logic [2:0]          ibar_o,
   output logic [IN_DW/2+8:0]  corr_o,
   output logic                ibar_valid_o,
   output logic                seq_ready_o,
   output logic                drop_o
);
   localparam int HW      = IN_DW/2;
   localparam int ACC_DW  = HW + 9;
   localparam int FFT_LEN = 2**NFFT;
   localparam int BASE    = FFT_LEN/2 - 120;
   localparam int HB      = $clog2(N_HYP);
   typedef enum logic [2:0] {G_IDLE, G_LOAD, G_WARM, G_FILL, G_DONE} gen_t;
   typedef enum logic [1:0] {D_IDLE, D_ACC, D_ARG, D_OUT} det_t;
   gen_t gst;
   det_t dst;
   logic [10:0] gcnt;
   logic [9:0] nid;
   logic [30:0] x1;
   logic [30:0] x2 [N_HYP];
   logic [287:0] seq [N_HYP];
   logic [IN_DW-1:0] in_q;
   logic in_v;
   logic [NFFT-1:0] n;
   logic [1:0] sym;
   logic signed [ACC_DW-1:0] acc [N_HYP];
   logic signed [ACC_DW-1:0] acc_nx [N_HYP];
   logic signed [ACC_DW-1:0] re, im, best_v, cand_v;
   logic [HB-1:0] hcnt, best_h, cand_h;
   logic signed [NFFT+1:0] k;
   logic [7:0] k8, m;
   logic [5:0] q;
   logic dmrs, take, last;
   always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) begin
         gst <= G_IDLE;
         gcnt <= '0;
         nid <= '0;
         seq_ready_o <= 1'b0;
      end else if (N_id_valid_i) begin
         gst <= G_LOAD;
         nid <= N_id_i;
         seq_ready_o <= 1'b0;
      end else
         case (gst)
            G_LOAD: begin
               gst <= G_WARM;
               gcnt <= '0;
            end
            G_WARM: begin
               gcnt <= gcnt + 11'd1;
               if (gcnt == 11'd1599) begin
                  gst <= G_FILL;
                  gcnt <= '0;
               end
            end
            G_FILL: begin
               gcnt <= gcnt + 11'd1;
               if (gcnt == 11'd287) begin
                  gst <= G_DONE;
                  seq_ready_o <= 1'b1;
               end
            end
            G_DONE: gst <= G_IDLE;
            default: ;
         endcase
   // Shared x1 plus one x2 per hypothesis; c(n) is taken from bit 0 after the 1600-shift warm-up
   always_ff @(posedge clk_i) begin
      if (gst == G_LOAD) begin
         x1 <= 31'd1;
         for (int h = 0; h < N_HYP; h++)
            x2[h] <= 31'((((h + 1) * (int'(nid[9:2]) + 1)) << 11) + ((h + 1) << 6) + int'(nid[1:0]));
      end else if (gst == G_WARM || gst == G_FILL) begin
         x1 <= {x1[3] ^ x1[0], x1[30:1]};
         for (int h = 0; h < N_HYP; h++)
            x2[h] <= {x2[h][3] ^ x2[h][2] ^ x2[h][1] ^ x2[h][0], x2[h][30:1]};
      end
      if (gst == G_FILL)
         for (int h = 0; h < N_HYP; h++)
            seq[h][gcnt[8:0]] <= x1[0] ^ x2[h][0];
   end
   assign k  = (NFFT+2)'(n) - (NFFT+2)'(BASE);
   assign k8 = k[7:0];
   assign q  = k8[7:2];
   assign dmrs = in_v && !k[NFFT+1] && k < (NFFT+2)'(240) && k8[1:0] == nid[1:0]
                 && (sym != 2'd1 || k8 < 8'd48 || k8 >= 8'd192);
   assign m  = sym == 2'd0 ? {2'b0, q} :
               sym == 2'd1 ? (k8 < 8'd48 ? {2'b0, q} + 8'd60 : {2'b0, q} + 8'd24) :
               {2'b0, q} + 8'd84;
   assign re = {{9{in_q[HW-1]}}, in_q[HW-1:0]};
   assign im = {{9{in_q[IN_DW-1]}}, in_q[IN_DW-1:HW]};
   assign last = in_v && (&n) && sym == 2'(N_SYM - 1);
   assign take = hcnt == '0 || acc[hcnt] > best_v;
   assign cand_v = take ? acc[hcnt] : best_v;
   assign cand_h = take ? hcnt : best_h;
   always_comb
      for (int h = 0; h < N_HYP; h++)
         acc_nx[h] = acc[h] + (seq[h][{m, 1'b0}] ? -re : re) + (seq[h][{m, 1'b1}] ? -im : im);
   always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) begin
         dst <= D_IDLE;
         in_q <= '0;
         in_v <= 1'b0;
         n <= '0;
         sym <= '0;
         hcnt <= '0;
         best_h <= '0;
         best_v <= '0;
         ibar_o <= '0;
         corr_o <= '0;
         ibar_valid_o <= 1'b0;
         drop_o <= 1'b0;
         for (int h = 0; h < N_HYP; h++)
            acc[h] <= '0;
      end else begin
         in_q <= s_axis_in_tdata;
         in_v <= s_axis_in_tvalid;
         drop_o <= 1'b0;
         ibar_valid_o <= 1'b0;
         if (N_id_valid_i) begin
            dst <= D_IDLE;
            for (int h = 0; h < N_HYP; h++)
               acc[h] <= '0;
         end else
            case (dst)
               D_IDLE:
                  if (PBCH_start_i) begin
                     if (seq_ready_o) begin
                        dst <= D_ACC;
                        n <= '0;
                        sym <= '0;
                     end else
                        drop_o <= 1'b1;
                  end
               D_ACC:
                  if (in_v) begin
                     n <= n + NFFT'(1);
                     if (&n)
                        sym <= sym + 2'd1;
                     if (dmrs)
                        acc <= acc_nx;
                     if (last) begin
                        dst <= D_ARG;
                        hcnt <= '0;
                     end
                  end
               D_ARG: begin
                  best_v <= cand_v;
                  best_h <= cand_h;
                  hcnt <= hcnt + HB'(1);
                  if (hcnt == HB'(N_HYP - 1)) begin
                     ibar_o <= 3'(cand_h);
                     corr_o <= cand_v;
                     ibar_valid_o <= 1'b1;
                     dst <= D_OUT;
                  end
               end
               D_OUT: begin
                  for (int h = 0; h < N_HYP; h++)
                     acc[h] <= '0;
                  dst <= D_IDLE;
               end
            endcase
      end
endmodule
